// File: rtl/shiftreg_rw_ctrl.sv
// Serial write/readback engine for the chip configuration shift register.
// Shifts din out MSB-first on sr_din/sr_clk, captures sr_dout into dout, then strobes sr_load.
module shiftreg_rw_ctrl #(
    parameter int SR_WIDTH  = 200,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                clk_div,
    input  logic                start,
    input  logic [SR_WIDTH-1:0] din,
    output logic                busy,
    output logic                done,
    output logic [SR_WIDTH-1:0] dout,
    output logic                sr_clk,
    output logic                sr_din,
    input  logic                sr_dout,
    output logic                sr_load
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SR_WIDTH - 1);

    state_t                state;
    logic                  clk_div_q;
    logic                  tick;
    logic [SR_WIDTH-1:0]   shreg;
    logic [SR_WIDTH-1:0]   capture;
    logic [CNT_WIDTH-1:0]  counter;

    // clk_div is treated as data: its rising edge becomes a one-cycle shift tick
    assign tick = clk_div & ~clk_div_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            clk_div_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
            sr_clk    <= 1'b0;
            sr_din    <= 1'b0;
            sr_load   <= 1'b0;
            shreg     <= '0;
            capture   <= '0;
            counter   <= '0;
        end else begin
            clk_div_q <= clk_div;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= din;
                        capture <= '0;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        sr_clk <= 1'b0;
                        sr_din <= shreg[SR_WIDTH-1];
                        state  <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sr_clk  <= 1'b1;
                        capture <= {capture[SR_WIDTH-2:0], sr_dout};
                        shreg   <= {shreg[SR_WIDTH-2:0], 1'b0};
                        counter <= counter + 1'b1;
                        state   <= (counter == LAST_CNT) ? LOAD : SHIFT_LO;
                    end
                end
                LOAD: begin
                    // sr_load itself marks whether the first LOAD tick has been seen
                    if (tick) begin
                        if (!sr_load) begin
                            sr_clk  <= 1'b0;
                            sr_din  <= 1'b0;
                            sr_load <= 1'b1;
                        end else begin
                            sr_load <= 1'b0;
                            dout    <= capture;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_rw_ctrl.sv
// Directed bench for shiftreg_rw_ctrl with SR_WIDTH=8 and a modelled clock divider.
module tb_shiftreg_rw_ctrl;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         clk_div = 1'b0;
    logic         start  = 1'b0;
    logic [W-1:0] din    = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         sr_clk;
    logic         sr_din;
    logic         sr_dout;
    logic         sr_load;

    shiftreg_rw_ctrl #(.SR_WIDTH(W), .CNT_WIDTH(4)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .clk_div (clk_div),
        .start   (start),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .sr_clk  (sr_clk),
        .sr_din  (sr_din),
        .sr_dout (sr_dout),
        .sr_load (sr_load)
    );

    always #5 clk_in = ~clk_in;

    // Clock divider model: div_mode N toggles clk_div every N cycles; 0 holds div_hold
    int   div_mode = 2;
    logic div_hold = 1'b0;
    int   div_cnt  = 0;
    always @(posedge clk_in) begin
        if (div_mode == 0) begin
            clk_div <= div_hold;
            div_cnt <= 0;
        end else if (div_cnt >= div_mode - 1) begin
            clk_div <= ~clk_div;
            div_cnt <= 0;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    logic div_q = 1'b0;
    always @(posedge clk_in) div_q <= clk_div;

    // Monitor and chip model; counters are monotonic, tests compare deltas
    int           rises = 0, dones = 0, load_cyc = 0, load_bad = 0, ticks = 0;
    logic [W-1:0] din_seq = '0;
    logic         sr_clk_prev = 1'b0;
    logic         chip_bit = 1'b0;
    logic [W-1:0] chip_pat = '0;
    logic         loopback = 1'b1;
    int           base_rises = 0;

    assign sr_dout = loopback ? sr_din : chip_bit;

    always @(negedge clk_in) begin
        int idx;
        if (sr_clk && !sr_clk_prev) begin
            rises++;
            din_seq = {din_seq[W-2:0], sr_din};
        end
        sr_clk_prev = sr_clk;
        if (done) dones++;
        if (sr_load) begin
            load_cyc++;
            if (sr_clk) load_bad++;
        end
        if (busy && !done && clk_div && !div_q) ticks++;
        idx = W - 1 - (rises - base_rises);
        chip_bit = (idx >= 0 && idx < W) ? chip_pat[idx[2:0]] : 1'b0;
    end

    int checks = 0, errors = 0;
    int b_rises, b_dones, b_load, b_lbad, b_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_rises    = rises;
        b_dones    = dones;
        b_load     = load_cyc;
        b_lbad     = load_bad;
        b_ticks    = ticks;
        base_rises = rises;
    endtask

    task automatic pulse_start(input logic [W-1:0] d);
        @(negedge clk_in);
        din   = d;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic timed_out);
        int n;
        n = 0;
        timed_out = 1'b1;
        while (n < budget) begin
            @(negedge clk_in);
            n++;
            if (dones > b_dones && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_xfer(input string tag, input logic [W-1:0] d, input logic lb,
                              input logic [W-1:0] exp, input int exp_load);
        logic to;
        wait_idle(300, to);
        repeat (2) @(negedge clk_in);
        check({tag, " timeout"}, 32'(to), 32'd0);
        check({tag, " dout"}, 32'(dout), 32'(exp));
        check({tag, " sr_clk rises"}, 32'(rises - b_rises), 32'd8);
        check({tag, " done cycles"}, 32'(dones - b_dones), 32'd1);
        check({tag, " ticks"}, 32'(ticks - b_ticks), 32'd18);
        check({tag, " sr_load cycles"}, 32'(load_cyc - b_load), 32'(exp_load));
        check({tag, " sr_clk during load"}, 32'(load_bad - b_lbad), 32'd0);
        if (lb) check({tag, " sr_din sequence"}, 32'(din_seq), 32'(d));
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] pat;
        logic         lb;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic to;
        int   n;

        vecs[0] = '{din: 8'hA5, pat: 8'h00, lb: 1'b1, exp: 8'hA5};
        vecs[1] = '{din: 8'hFF, pat: 8'h3C, lb: 1'b0, exp: 8'h3C};
        vecs[2] = '{din: 8'h00, pat: 8'hC3, lb: 1'b0, exp: 8'hC3};
        vecs[3] = '{din: 8'h5A, pat: 8'h00, lb: 1'b1, exp: 8'h5A};
        vecs[4] = '{din: 8'h80, pat: 8'h01, lb: 1'b0, exp: 8'h01};

        // Reset state
        repeat (3) @(negedge clk_in);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        check("reset sr_clk", 32'(sr_clk), 32'd0);
        check("reset sr_din", 32'(sr_din), 32'd0);
        check("reset sr_load", 32'(sr_load), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_in);

        // Table-driven transfers at div=2 (tick every 4 cycles, sr_load 4 cycles wide)
        for (int i = 0; i < 5; i++) begin
            loopback = vecs[i].lb;
            chip_pat = vecs[i].pat;
            snap();
            pulse_start(vecs[i].din);
            check_xfer($sformatf("vec%0d", i), vecs[i].din, vecs[i].lb, vecs[i].exp, 4);
        end

        // Second start 5 cycles after the first is ignored; din change has no effect
        loopback = 1'b1;
        snap();
        pulse_start(8'h3C);
        repeat (3) @(negedge clk_in);
        pulse_start(8'hFF);
        check_xfer("restart ignored", 8'h3C, 1'b1, 8'h3C, 4);

        // Reset after the 3rd sr_clk rise
        snap();
        pulse_start(8'hA5);
        n = 0;
        while ((rises - b_rises) < 3 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        check("mid rst wait", 32'(n < 200), 32'd1);
        rst = 1'b1;
        @(negedge clk_in);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst sr_clk", 32'(sr_clk), 32'd0);
        check("mid rst sr_load", 32'(sr_load), 32'd0);
        check("mid rst dout", 32'(dout), 32'd0);
        check("mid rst no done", 32'(dones - b_dones), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
        snap();
        pulse_start(8'hC6);
        check_xfer("after rst", 8'hC6, 1'b1, 8'hC6, 4);

        // clk_div high at reset release, then div=1
        rst      = 1'b1;
        div_mode = 0;
        div_hold = 1'b1;
        repeat (3) @(negedge clk_in);
        snap();
        rst   = 1'b0;
        din   = 8'h96;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (6) @(negedge clk_in);
        check("div high busy", 32'(busy), 32'd1);
        check("div high sr_din", 32'(sr_din), 32'd0);
        check("div high sr_clk", 32'(sr_clk), 32'd0);
        div_mode = 1;
        check_xfer("div1", 8'h96, 1'b1, 8'h96, 2);

        // div=0 modelled as constant-low clk_div: no ticks, FSM stalls
        div_mode = 0;
        div_hold = 1'b0;
        repeat (3) @(negedge clk_in);
        snap();
        pulse_start(8'hFF);
        repeat (40) @(negedge clk_in);
        check("stall busy", 32'(busy), 32'd1);
        check("stall sr_clk", 32'(sr_clk), 32'd0);
        check("stall rises", 32'(rises - b_rises), 32'd0);
        check("stall no done", 32'(dones - b_dones), 32'd0);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check("stall rst busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
